// File: rtl/scic_control_unit.sv
// Fetch/decode/execute sequencer for the SCIC accumulator core, with memory wait-state watchdog.
// Define SCIC_INSTR_COUNT_EN to add the saturating instr_count output.
module scic_control_unit #(
    parameter int ADDR_W      = 5,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [2:0]        ir_opcode,
    input  logic [ADDR_W-1:0] ir_operand,
    input  logic              acc_zero,
    input  logic              mem_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic              addr_sel,
    output logic              ir_load,
    output logic              pc_inc,
    output logic              pc_load,
    output logic              acc_load,
    output logic [1:0]        acc_src,
    output logic              alu_op,
    output logic              led_load,
    output logic              halted,
    output logic              fault
`ifdef SCIC_INSTR_COUNT_EN
    ,
    output logic [15:0]       instr_count
`endif
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        MEMRD  = 3'd2,
        MEMWR  = 3'd3,
        EXEC   = 3'd4,
        HALT   = 3'd5
    } state_t;

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_STORE = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_IN    = 3'b100;
    localparam logic [2:0] OP_OUT   = 3'b101;
    localparam logic [2:0] OP_JMP   = 3'b110;
    localparam logic [2:0] OP_BRZ   = 3'b111;

    localparam logic [1:0] SRC_MEM = 2'b00;
    localparam logic [1:0] SRC_ALU = 2'b01;
    localparam logic [1:0] SRC_SW  = 2'b10;

    localparam int               CNT_W     = 8;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             fault_q, fault_d;
    logic             mem_state;
    logic             timeout_hit;
    logic             halt_instr;

    assign mem_state   = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);
    // The cycle that would make the count reach MEM_TIMEOUT; a late mem_ready still wins.
    assign timeout_hit = mem_state && !mem_ready && (wait_cnt_q == WAIT_LAST);
    assign halt_instr  = (ir_opcode == OP_BRZ) && (&ir_operand);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= FETCH;
            wait_cnt_q <= '0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            fault_q    <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH, MEMRD, MEMWR: begin
                if (mem_ready) begin
                    state_d = (state_q == FETCH) ? DECODE : FETCH;
                end else if (timeout_hit) begin
                    state_d = HALT;
                end
            end
            DECODE: begin
                case (ir_opcode)
                    OP_LOAD, OP_ADD, OP_SUB: state_d = MEMRD;
                    OP_STORE:                state_d = MEMWR;
                    OP_IN, OP_OUT, OP_JMP:   state_d = EXEC;
                    default:                 state_d = halt_instr ? HALT : EXEC;
                endcase
            end
            EXEC:    state_d = FETCH;
            default: state_d = HALT;
        endcase
    end

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_d != state_q) begin
            wait_cnt_d = '0;
        end else if (mem_state && !mem_ready) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    assign fault_d = fault_q | timeout_hit;

    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        addr_sel  = 1'b0;
        ir_load   = 1'b0;
        pc_inc    = 1'b0;
        pc_load   = 1'b0;
        acc_load  = 1'b0;
        acc_src   = SRC_MEM;
        alu_op    = 1'b0;
        led_load  = 1'b0;
        if (!reset) begin
            case (state_q)
                FETCH: begin
                    mem_read = 1'b1;
                    ir_load  = mem_ready;
                    pc_inc   = mem_ready;
                end
                MEMRD: begin
                    mem_read = 1'b1;
                    addr_sel = 1'b1;
                    acc_load = mem_ready;
                    acc_src  = (ir_opcode == OP_LOAD) ? SRC_MEM : SRC_ALU;
                    alu_op   = (ir_opcode == OP_SUB);
                end
                MEMWR: begin
                    mem_write = 1'b1;
                    addr_sel  = 1'b1;
                end
                EXEC: begin
                    case (ir_opcode)
                        OP_IN: begin
                            acc_load = 1'b1;
                            acc_src  = SRC_SW;
                        end
                        OP_OUT:  led_load = 1'b1;
                        OP_JMP:  pc_load  = 1'b1;
                        OP_BRZ:  pc_load  = acc_zero;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign halted = (state_q == HALT);
    assign fault  = fault_q;

`ifdef SCIC_INSTR_COUNT_EN
    logic [15:0] instr_count_q, instr_count_d;
    logic        instr_done;

    // An instruction retires when an execute-class state hands back to FETCH.
    assign instr_done = (state_d == FETCH) &&
                        ((state_q == MEMRD) || (state_q == MEMWR) || (state_q == EXEC));

    always_comb begin
        instr_count_d = instr_count_q;
        if (instr_done && (instr_count_q != 16'hFFFF)) begin
            instr_count_d = instr_count_q + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            instr_count_q <= 16'd0;
        end else begin
            instr_count_q <= instr_count_d;
        end
    end

    assign instr_count = instr_count_q;
`endif

endmodule

// File: tb/tb_scic_control_unit.sv
// Directed bench for scic_control_unit with a small datapath/memory model around it.
module tb_scic_control_unit;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] ir_opcode;
  logic [4:0] ir_operand;
  logic       acc_zero;
  logic       mem_ready = 1'b1;
  logic       mem_read, mem_write, addr_sel, ir_load, pc_inc, pc_load;
  logic       acc_load, alu_op, led_load, halted, fault;
  logic [1:0] acc_src;
`ifdef SCIC_INSTR_COUNT_EN
  logic [15:0] instr_count;
`endif

  int total = 0;
  int bad   = 0;

  logic [7:0] mem [0:31];
  logic [4:0] pc;
  logic [7:0] ir;
  logic [7:0] acc;
  logic [3:0] led;
  logic [7:0] sw = 8'd0;
  int         led_pulses;
  logic [4:0] addr;
  logic [10:0] strobes;

  scic_control_unit #(.ADDR_W(5), .MEM_TIMEOUT(15)) dut (
    .clock      (clock),
    .reset      (reset),
    .ir_opcode  (ir_opcode),
    .ir_operand (ir_operand),
    .acc_zero   (acc_zero),
    .mem_ready  (mem_ready),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .addr_sel   (addr_sel),
    .ir_load    (ir_load),
    .pc_inc     (pc_inc),
    .pc_load    (pc_load),
    .acc_load   (acc_load),
    .acc_src    (acc_src),
    .alu_op     (alu_op),
    .led_load   (led_load),
    .halted     (halted),
    .fault      (fault)
`ifdef SCIC_INSTR_COUNT_EN
    ,
    .instr_count(instr_count)
`endif
  );

  always #5 clock = ~clock;

  assign ir_opcode  = ir[7:5];
  assign ir_operand = ir[4:0];
  assign acc_zero   = (acc == 8'd0);
  assign addr       = addr_sel ? ir[4:0] : pc;
  assign strobes    = {mem_read, mem_write, addr_sel, ir_load, pc_inc, pc_load,
                       acc_load, acc_src, alu_op, led_load};

  // Datapath model: PC, IR, ACC and LED register driven by the sequencer strobes.
  always @(posedge clock) begin
    if (reset) begin
      pc         <= 5'd0;
      ir         <= 8'd0;
      acc        <= 8'd0;
      led        <= 4'd0;
      led_pulses <= 0;
    end else begin
      if (ir_load) ir <= mem[addr];
      if (pc_inc) pc <= pc + 5'd1;
      else if (pc_load) pc <= ir[4:0];
      if (acc_load) begin
        case (acc_src)
          2'b00:   acc <= mem[addr];
          2'b01:   acc <= alu_op ? (acc - mem[addr]) : (acc + mem[addr]);
          2'b10:   acc <= sw;
          default: acc <= acc;
        endcase
      end
      if (led_load) begin
        led        <= acc[3:0];
        led_pulses <= led_pulses + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    // Reset behaviour and LOAD 5 / ADD 6 / OUT / HALT program
    clear_mem();
    mem[0] = 8'h05; mem[1] = 8'h46; mem[2] = 8'hA0; mem[3] = 8'hFF;
    mem[5] = 8'h03; mem[6] = 8'h04;
    mem_ready = 1'b1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_strobes", strobes, 11'd0);
    end
    reset = 1'b0;
    #1;
    chk("c1_mem_read", mem_read, 1'b1);
    chk("c1_addr_sel", addr_sel, 1'b0);
    chk("c1_ir_load", ir_load, 1'b1);
    chk("c1_pc_inc", pc_inc, 1'b1);
    for (int c = 2; c <= 12; c++) begin
      tick();
      if (c == 3) begin
        chk("load_acc_load", acc_load, 1'b1);
        chk("load_acc_src", acc_src, 2'b00);
        chk("load_addr_sel", addr_sel, 1'b1);
      end
      if (c == 5) chk("decode_strobes", strobes, 11'd0);
      if (c == 6) begin
        chk("add_acc_src", acc_src, 2'b01);
        chk("add_alu_op", alu_op, 1'b0);
      end
      if (c == 9) chk("out_led_load", led_load, 1'b1);
      if (c == 11) chk("halted_c11", halted, 1'b0);
    end
    chk("halted_c12", halted, 1'b1);
    chk("fault_c12", fault, 1'b0);
    chk("halt_strobes", strobes, 11'd0);
    chk("led_value", led, 4'b0111);
    chk("led_pulses", led_pulses, 1);
`ifdef SCIC_INSTR_COUNT_EN
    chk("icount_halt", instr_count, 16'd3);
    tick(); tick(); tick();
    chk("icount_hold", instr_count, 16'd3);
`endif
    tick(); tick();
    chk("halt_sticky", halted, 1'b1);

    // BRZ taken (ACC = 0)
    clear_mem();
    mem[0] = 8'h14; mem[1] = 8'hE9; mem[9] = 8'hFF; mem[20] = 8'h00;
    apply_reset();
    chk("brz_c1_halted", halted, 1'b0);
`ifdef SCIC_INSTR_COUNT_EN
    chk("icount_reset", instr_count, 16'd0);
`endif
    for (int c = 2; c <= 6; c++) tick();
    chk("brz_taken_pc_load", pc_load, 1'b1);
    chk("brz_taken_pc_inc", pc_inc, 1'b0);
    tick();
    chk("brz_taken_pc", pc, 5'd9);
    chk("brz_taken_fetch", mem_read, 1'b1);

    // BRZ not taken (ACC = 2)
    clear_mem();
    mem[0] = 8'h15; mem[1] = 8'hE9; mem[2] = 8'hFF; mem[9] = 8'hFF; mem[21] = 8'h02;
    apply_reset();
    for (int c = 2; c <= 6; c++) tick();
    chk("brz_nt_pc_load", pc_load, 1'b0);
    tick();
    chk("brz_nt_pc", pc, 5'd2);

    // STORE with memory stuck: timeout after 15 wait cycles
    clear_mem();
    mem[0] = 8'h2A; mem[1] = 8'hFF;
    apply_reset();
    tick();
    mem_ready = 1'b0;
    for (int c = 3; c <= 17; c++) begin
      tick();
      if (c == 3) begin
        chk("store_mem_write", mem_write, 1'b1);
        chk("store_addr_sel", addr_sel, 1'b1);
      end
    end
    chk("to_c17_halted", halted, 1'b0);
    chk("to_c17_fault", fault, 1'b0);
    tick();
    chk("to_halted", halted, 1'b1);
    chk("to_fault", fault, 1'b1);
    chk("to_strobes", strobes, 11'd0);

    // STORE with mem_ready arriving on the 15th wait cycle
    mem_ready = 1'b1;
    apply_reset();
    chk("late_c1_fault", fault, 1'b0);
    tick();
    mem_ready = 1'b0;
    for (int c = 3; c <= 16; c++) tick();
    tick();
    mem_ready = 1'b1;
    #1;
    chk("late_c17_mem_write", mem_write, 1'b1);
    tick();
    chk("late_fault", fault, 1'b0);
    chk("late_halted", halted, 1'b0);
    chk("late_fetch", mem_read, 1'b1);
    chk("late_pc", pc, 5'd1);

    // Reset during a stalled MEMRD
    clear_mem();
    mem[0] = 8'h05; mem[5] = 8'h03;
    apply_reset();
    tick();
    mem_ready = 1'b0;
    tick();
    chk("rdstall_c3_addr_sel", addr_sel, 1'b1);
    tick();
    chk("rdstall_c4_mem_read", mem_read, 1'b1);
    chk("rdstall_c4_acc_load", acc_load, 1'b0);
    tick();
    reset = 1'b1;
    #1;
    chk("rdstall_rst_strobes", strobes, 11'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("rdstall_fetch_read", mem_read, 1'b1);
    chk("rdstall_fetch_sel", addr_sel, 1'b0);
    chk("rdstall_fault", fault, 1'b0);
    chk("rdstall_acc", acc, 8'd0);
    for (int c = 2; c <= 15; c++) tick();
    chk("rdstall_cnt_cleared", halted, 1'b0);
    tick();
    chk("fetch_to_halted", halted, 1'b1);
    chk("fetch_to_fault", fault, 1'b1);

    // JMP 4 / IN / SUB 10 / OUT / HALT with switches = 9
    clear_mem();
    mem[0] = 8'hC4; mem[4] = 8'h80; mem[5] = 8'h6A; mem[6] = 8'hA0; mem[7] = 8'hFF;
    mem[10] = 8'h03;
    sw = 8'd9;
    mem_ready = 1'b1;
    apply_reset();
    for (int c = 2; c <= 15; c++) begin
      tick();
      if (c == 3) chk("jmp_pc_load", pc_load, 1'b1);
      if (c == 6) begin
        chk("in_acc_load", acc_load, 1'b1);
        chk("in_acc_src", acc_src, 2'b10);
      end
      if (c == 9) begin
        chk("sub_acc_src", acc_src, 2'b01);
        chk("sub_alu_op", alu_op, 1'b1);
      end
    end
    chk("prog2_acc", acc, 8'd6);
    chk("prog2_led", led, 4'd6);
    chk("prog2_halted", halted, 1'b1);
    chk("prog2_fault", fault, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
